dc_1_tagcheck: RTL
==================

Name: dc_1_tagcheck

Overview:
Downstream consumer of the per-way tag banks in the L1 data cache pipe. It queues core requests (tag, set position, request type) and pairs each with the tag-bank read acknowledgement for that set. It compares all ways, reports hit/way/state or a victim way, and issues a single-entry write-back of the updated state and counter bits to the tag bank.

Parameters:
Width, 24, tag-bank entry width: tag [17:0], bit 18 reserved, counter [20:19], state [23:21]
Size, 32, sets per tag bank; position width is `log2(Size)
Ways, 4, ways delivered in parallel per ack (power of 2, 2..8)
TypeBits, 5, request-type field width (`CORE_LOP_*` / `CORE_MOP_*` codes)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
req_valid  in  1  new lookup request
req_retry  out  1  request not accepted this cycle
req_tag  in  18  lookup tag
req_pos  in  `log2(Size)  set position
req_type  in  TypeBits  request type
tag_ack_valid  in  1  tag-bank read data valid (FIFO order)
tag_ack_retry  out  1  backpressure to tag banks
tag_ack_data  in  Ways*Width  way w occupies [w*Width +: Width]
res_valid  out  1  lookup result valid
res_retry  in  1  consumer stall
res_hit  out  1  hit
res_way  out  `log2(Ways)  hit way, else victim way
res_state  out  3  state of hit way (I on miss)
upd_valid  out  1  tag-bank write request
upd_retry  in  1  tag-bank write stall
upd_pos  out  `log2(Size)  write set position
upd_way  out  `log2(Ways)  write way
upd_data  out  Width  new entry
err_multihit  out  1  sticky: more than one way matched

Behaviour:
- State codes: I=000, S=001, E=010, M=011, US=100, UM=101.
- Reset (reset==0, async): FIFO empty, res_valid=0, upd_valid=0, err_multihit=0, all other registered outputs 0.
- Request FIFO: depth 2. req_retry = FIFO full. Push on req_valid && !req_retry. Simultaneous push and pop allowed when full (pop frees the slot in the same cycle).
- Ack accept: tag_ack_valid && !tag_ack_retry. tag_ack_retry = FIFO empty || (res_valid && res_retry) || (upd_valid && upd_retry). An accepted ack pops the FIFO head.
- Compare: way w matches if state!=I and entry[17:0]==head tag. With multiple matches, pick the lowest index and set err_multihit (cleared only by reset).
- Miss victim: lowest way in state I; if none, lowest way with minimum counter.
- Hit next state:
  - `CORE_LOP_*` loads: unchanged.
  - `CORE_MOP_BEGIN`: UM->US, else unchanged.
  - `CORE_MOP_COMMIT`/`CORE_MOP_CSYNC`: US->S, else unchanged.
  - `CORE_MOP_KILL`/`CORE_MOP_RESTART`: ->I.
  - Other types: unchanged.
- Hit counter: saturating +1 at 3. It resets to 0 when the next state is I.
- Miss: no update.
- upd_valid is asserted only if the entry changes (state or counter). upd_data = old entry with new [23:19]; tag and bit 18 preserved.
- Latency: res_* and upd_* are registered exactly 1 cycle after ack accept.
- res_* are held stable while res_valid && res_retry; upd_* are held stable while upd_valid && upd_retry. The two channels drain independently, and each deasserts on its own handshake.
- Reset mid-operation: queued requests and pending results/updates are discarded.

Test Plan:
- Reset with reset=0 mid-burst -> req_retry=0, res_valid=0, upd_valid=0, err_multihit=0 immediately, without waiting for a clk edge.
- req tag 0x1234A, pos 5, type `CORE_LOP_L64U`; ack way2 = {E, cnt 1, tag 0x1234A}, others I -> next cycle res_hit=1, res_way=2, res_state=E; upd_valid=1, upd_way=2, upd_pos=5, upd_data[23:19]={E,2}.
- Same hit with cnt=3 and state S under a load -> res_hit=1, upd_valid=0 (no change).
- Miss: all ways valid with tags differing, counters {3,1,0,0} -> res_hit=0, res_way=2, res_state=I, upd_valid=0. With way3 in state I instead -> res_way=3.
- `CORE_MOP_COMMIT` hit on US entry (way1, cnt 2) -> res_state=US, upd_data[23:19]={S,3}. `CORE_MOP_KILL` hit -> upd_data[23:19]={I,0}.
- Backpressure: 3 back-to-back requests -> third sees req_retry=1. Hold res_retry=1 for 4 cycles -> tag_ack_retry=1 and res_* stable. Two matching ways (0, 3) -> res_way=0 and err_multihit=1 latched.

Source files
------------

// File: rtl/dc_1_tagcheck.sv
// dc_1_tagcheck: queues core lookups, pairs them with tag-bank acks, reports hit/victim
// and issues a single-entry state/counter write-back to the tag bank.
module dc_1_tagcheck #(
    parameter int Width    = 24,
    parameter int Size     = 32,
    parameter int Ways     = 4,
    parameter int TypeBits = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_retry,
    input  logic [17:0]              req_tag,
    input  logic [$clog2(Size)-1:0]  req_pos,
    input  logic [TypeBits-1:0]      req_type,
    input  logic                     tag_ack_valid,
    output logic                     tag_ack_retry,
    input  logic [Ways*Width-1:0]    tag_ack_data,
    output logic                     res_valid,
    input  logic                     res_retry,
    output logic                     res_hit,
    output logic [$clog2(Ways)-1:0]  res_way,
    output logic [2:0]               res_state,
    output logic                     upd_valid,
    input  logic                     upd_retry,
    output logic [$clog2(Size)-1:0]  upd_pos,
    output logic [$clog2(Ways)-1:0]  upd_way,
    output logic [Width-1:0]         upd_data,
    output logic                     err_multihit
);
    localparam int PB = $clog2(Size);
    localparam int WB = $clog2(Ways);
    localparam logic [2:0] ST_I = 3'd0, ST_S = 3'd1, ST_US = 3'd4, ST_UM = 3'd5;
    localparam logic [TypeBits-1:0] CORE_MOP_BEGIN   = TypeBits'(5'h10);
    localparam logic [TypeBits-1:0] CORE_MOP_COMMIT  = TypeBits'(5'h11);
    localparam logic [TypeBits-1:0] CORE_MOP_CSYNC   = TypeBits'(5'h12);
    localparam logic [TypeBits-1:0] CORE_MOP_KILL    = TypeBits'(5'h13);
    localparam logic [TypeBits-1:0] CORE_MOP_RESTART = TypeBits'(5'h14);

    logic [17:0]         q_tag  [2];
    logic [PB-1:0]       q_pos  [2];
    logic [TypeBits-1:0] q_type [2];
    logic                rd_ptr, wr_ptr;
    logic [1:0]          count;
    logic                ack_acc, push;
    logic [17:0]         h_tag;
    logic [PB-1:0]       h_pos;
    logic [TypeBits-1:0] h_type;

    assign tag_ack_retry = (count == 2'd0) || (res_valid && res_retry) || (upd_valid && upd_retry);
    assign ack_acc       = tag_ack_valid && !tag_ack_retry;
    // a pop in the same cycle frees the slot, so a full FIFO can still take a push
    assign req_retry     = (count == 2'd2) && !ack_acc;
    assign push          = req_valid && !req_retry;
    assign h_tag         = q_tag[rd_ptr];
    assign h_pos         = q_pos[rd_ptr];
    assign h_type        = q_type[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            q_tag[wr_ptr]  <= req_tag;
            q_pos[wr_ptr]  <= req_pos;
            q_type[wr_ptr] <= req_type;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (ack_acc) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, ack_acc};
        end
    end

    logic [Width-1:0] e, he;
    logic             hit, multi, inv;
    logic [WB-1:0]    hit_way, inv_way, min_way, vic_way;
    logic [1:0]       min_cnt, old_cnt, new_cnt;
    logic [2:0]       old_st, new_st;
    logic             changed;

    always_comb begin
        e       = '0;
        hit     = 1'b0;
        multi   = 1'b0;
        inv     = 1'b0;
        hit_way = '0;
        inv_way = '0;
        min_way = '0;
        min_cnt = 2'd3;
        for (int w = 0; w < Ways; w++) begin
            e = tag_ack_data[w*Width +: Width];
            if (e[23:21] != ST_I && e[17:0] == h_tag) begin
                multi   = multi | hit;
                hit_way = hit ? hit_way : WB'(w);
                hit     = 1'b1;
            end
            if (e[23:21] == ST_I && !inv) begin
                inv     = 1'b1;
                inv_way = WB'(w);
            end
            // strict compare keeps the lowest way among equal minimum counters
            if (e[20:19] < min_cnt) begin
                min_cnt = e[20:19];
                min_way = WB'(w);
            end
        end
    end

    assign vic_way = inv ? inv_way : min_way;
    assign he      = tag_ack_data[hit_way*Width +: Width];
    assign old_st  = he[23:21];
    assign old_cnt = he[20:19];
    assign new_st  = (h_type == CORE_MOP_KILL || h_type == CORE_MOP_RESTART) ? ST_I :
                     (h_type == CORE_MOP_BEGIN && old_st == ST_UM) ? ST_US :
                     ((h_type == CORE_MOP_COMMIT || h_type == CORE_MOP_CSYNC) && old_st == ST_US) ? ST_S :
                     old_st;
    assign new_cnt = (new_st == ST_I) ? 2'd0 : (old_cnt == 2'd3) ? 2'd3 : old_cnt + 2'd1;
    assign changed = {new_st, new_cnt} != {old_st, old_cnt};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid    <= 1'b0;
            res_hit      <= 1'b0;
            res_way      <= '0;
            res_state    <= ST_I;
            upd_valid    <= 1'b0;
            upd_pos      <= '0;
            upd_way      <= '0;
            upd_data     <= '0;
            err_multihit <= 1'b0;
        end else if (ack_acc) begin
            res_valid    <= 1'b1;
            res_hit      <= hit;
            res_way      <= hit ? hit_way : vic_way;
            res_state    <= hit ? old_st : ST_I;
            upd_valid    <= hit && changed;
            upd_pos      <= h_pos;
            upd_way      <= hit_way;
            upd_data     <= {new_st, new_cnt, he[18:0]};
            err_multihit <= err_multihit | multi;
        end else begin
            if (!res_retry) res_valid <= 1'b0;
            if (!upd_retry) upd_valid <= 1'b0;
        end
    end
endmodule
